// File: rtl/slice_perm_engine.sv
// Buffered slice permutation engine: loads DEPTH 25-bit slices, applies identity/pi/rho/rho+pi, writes them back.
// Optional inverse permutations are compiled in with `define PERM_INVERSE_EN.
module slice_perm_engine #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              inv,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [24:0]       rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [24:0]       wr_data
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned       DEPTH_U = DEPTH;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRAIN = 3'd2,
        S_STORE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic int unsigned rho_off(input int unsigned p);
        int unsigned r;
        case (p)
            0: r = 32'd0;   1: r = 32'd1;   2: r = 32'd62;  3: r = 32'd28;  4: r = 32'd27;
            5: r = 32'd36;  6: r = 32'd44;  7: r = 32'd6;   8: r = 32'd55;  9: r = 32'd20;
            10: r = 32'd3;  11: r = 32'd10; 12: r = 32'd43; 13: r = 32'd25; 14: r = 32'd39;
            15: r = 32'd41; 16: r = 32'd45; 17: r = 32'd15; 18: r = 32'd21; 19: r = 32'd8;
            20: r = 32'd18; 21: r = 32'd2;  22: r = 32'd61; 23: r = 32'd56; 24: r = 32'd14;
            default: r = 32'd0;
        endcase
        return r % DEPTH_U;
    endfunction

    // Source slice for bit p of output slice z: z - r forward, z + r inverse, both mod DEPTH.
    function automatic logic [IDX_W-1:0] rho_src(input logic [ADDR_W-1:0] z, input int unsigned p,
                                                 input logic inv_dir);
        int unsigned s;
        if (inv_dir) begin
            s = 32'(z) + rho_off(p);
        end else begin
            s = 32'(z) + DEPTH_U - rho_off(p);
        end
        if (s >= DEPTH_U) begin
            s = s - DEPTH_U;
        end
        return IDX_W'(s);
    endfunction

    function automatic logic [24:0] pi_fwd(input logic [24:0] s);
        logic [24:0] o;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                o[5'(5 * y + x)] = s[5'(5 * x + (x + 3 * y) % 5)];
            end
        end
        return o;
    endfunction

    function automatic logic [24:0] pi_inv(input logic [24:0] s);
        logic [24:0] o;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                o[5'(5 * y + x)] = s[5'(5 * ((2 * x + 3 * y) % 5) + y)];
            end
        end
        return o;
    endfunction

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [24:0]       wr_data_q, wr_data_d;
    logic [1:0]        mode_q, mode_d;
    logic              cap_vld_q, cap_vld_d;
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [24:0]       buf_q [DEPTH];

    logic [24:0]       buf_view_s [DEPTH];
    logic [ADDR_W-1:0] perm_z_s;
    logic [24:0]       direct_s;
    logic [24:0]       rho_v_s;
    logic [24:0]       perm_data_s;

`ifdef PERM_INVERSE_EN
    logic              inv_q, inv_d;
    logic [24:0]       src_arr_s [DEPTH];
`else
    logic              inv_unused_s;
    assign inv_unused_s = inv;
`endif

    // Slice under permutation: 0 while draining, next write address while storing.
    assign perm_z_s = (state_q == S_STORE && wr_addr_q != LAST) ? wr_addr_q + 1'b1 : '0;

    // Permutation datapath; the buffer view forwards the slice being captured this cycle.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            buf_view_s[j] = (cap_vld_q && cap_addr_q == ADDR_W'(j)) ? rd_data : buf_q[j];
        end
`ifdef PERM_INVERSE_EN
        for (int j = 0; j < DEPTH; j++) begin
            src_arr_s[j] = (inv_q && mode_q == 2'b11) ? pi_inv(buf_view_s[j]) : buf_view_s[j];
        end
        for (int p = 0; p < 25; p++) begin
            rho_v_s[5'(p)] = src_arr_s[rho_src(perm_z_s, p, inv_q)][5'(p)];
        end
`else
        for (int p = 0; p < 25; p++) begin
            rho_v_s[5'(p)] = buf_view_s[rho_src(perm_z_s, p, 1'b0)][5'(p)];
        end
`endif
        direct_s = buf_view_s[IDX_W'(perm_z_s)];
        case (mode_q)
            2'b00: perm_data_s = direct_s;
            2'b01: begin
`ifdef PERM_INVERSE_EN
                if (inv_q) perm_data_s = pi_inv(direct_s);
                else
`endif
                perm_data_s = pi_fwd(direct_s);
            end
            2'b10: perm_data_s = rho_v_s;
            2'b11: begin
`ifdef PERM_INVERSE_EN
                if (inv_q) perm_data_s = rho_v_s;
                else
`endif
                perm_data_s = pi_fwd(rho_v_s);
            end
            default: perm_data_s = direct_s;
        endcase
    end

    // Sequencer next-state: load all slices, one drain cycle, store all slices, pulse done.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mode_d     = mode_q;
        cap_vld_d  = rd_en_q;
        cap_addr_d = rd_addr_q;
`ifdef PERM_INVERSE_EN
        inv_d      = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    mode_d    = mode;
`ifdef PERM_INVERSE_EN
                    inv_d     = inv;
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (rd_addr_q == LAST) begin
                    state_d   = S_DRAIN;
                    rd_addr_d = '0;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                state_d   = S_STORE;
                wr_en_d   = 1'b1;
                wr_addr_d = '0;
                wr_data_d = perm_data_s;
            end
            S_STORE: begin
                if (wr_addr_q == LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = 25'd0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = perm_data_s;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 25'd0;
            mode_q     <= 2'b00;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= '0;
`ifdef PERM_INVERSE_EN
            inv_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            mode_q     <= mode_d;
            cap_vld_q  <= cap_vld_d;
            cap_addr_q <= cap_addr_d;
`ifdef PERM_INVERSE_EN
            inv_q      <= inv_d;
`endif
        end
    end

    // State buffer: no reset, it is always fully reloaded before any slice is emitted.
    always_ff @(posedge clk) begin
        if (cap_vld_q) begin
            buf_q[IDX_W'(cap_addr_q)] <= rd_data;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_slice_perm_engine.sv
// Directed bench for slice_perm_engine: a DEPTH=64 instance plus a DEPTH=8 instance for rho wrap-around.
module tb_slice_perm_engine;

    logic        clk = 1'b0;
    logic        rst_n, start, start8, inv;
    logic [1:0]  mode;
    logic        busy, done, rd_en, wr_en;
    logic [5:0]  rd_addr, wr_addr;
    logic [24:0] rd_data, wr_data;
    logic        busy8, done8, rd_en8, wr_en8;
    logic [2:0]  rd_addr8, wr_addr8;
    logic [24:0] rd_data8, wr_data8;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [24:0] mem64 [64];
    logic [24:0] out64 [64];
    logic [24:0] mdl_in [64];
    logic [24:0] exp64 [64];
    logic [24:0] mem8 [8];
    logic [24:0] out8 [8];

    int rtab [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                      41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    always #5 clk = ~clk;

    slice_perm_engine #(.DEPTH(64), .ADDR_W(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .inv(inv),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    slice_perm_engine #(.DEPTH(8), .ADDR_W(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode), .inv(inv),
        .busy(busy8), .done(done8), .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .wr_en(wr_en8), .wr_addr(wr_addr8), .wr_data(wr_data8)
    );

    // Synchronous state memories: data returned the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem64[rd_addr];
        if (rd_en8) rd_data8 <= mem8[rd_addr8];
    end

    // Write capture and event counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            out64[wr_addr] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (wr_en8) out8[wr_addr8] <= wr_data8;
        if (rd_en) rd_cnt <= rd_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Forward rho-then-pi over mdl_in into exp64.
    task automatic model_fwd11();
        logic [24:0] t;
        for (int z = 0; z < 64; z++) begin
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    t[5 * y + x] = mdl_in[(z + 64 - rtab[5 * y + x]) % 64][5 * y + x];
                end
            end
            for (int y = 0; y < 5; y++) begin
                for (int x = 0; x < 5; x++) begin
                    exp64[z][5 * y + x] = t[5 * x + (x + 3 * y) % 5];
                end
            end
        end
    endtask

    // One operation: start edge, then cycles counted until done; optional start pulses while busy.
    task automatic do_op(input logic [1:0] m, input logic iv, input bit extra,
                         output int dcyc, output int rds, output int dns);
        int r0, d0, cyc;
        @(negedge clk);
        mode = m; inv = iv; start = 1'b1; start8 = 1'b1;
        r0 = rd_cnt; d0 = done_cnt;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        mode = m ^ 2'b11; inv = ~iv;
        cyc = 1; dcyc = -1;
        while (cyc < 400 && dcyc < 0) begin
            if (done) begin
                dcyc = cyc;
            end else begin
                @(negedge clk);
                cyc++;
                start = extra && (cyc == 20 || cyc == 70 || cyc == 130);
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        rds = rd_cnt - r0;
        dns = done_cnt - d0;
    endtask

    function automatic int diff64();
        int bad = 0;
        for (int z = 0; z < 64; z++) if (out64[z] !== exp64[z]) bad++;
        return bad;
    endfunction

    initial begin
        int dcyc, rds, dns, w0, d0, n;

        // Reset held with start high.
        rst_n = 1'b0; start = 1'b1; start8 = 1'b1; mode = 2'b00; inv = 1'b0;
        for (int z = 0; z < 64; z++) mem64[z] = 25'(z + 100);
        for (int z = 0; z < 8; z++) mem8[z] = 25'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_no_reads", 32'(rd_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_rd_en", 32'(rd_en), 32'd1);
        check("first_rd_addr", 32'(rd_addr), 32'd0);
        check("first_busy", 32'(busy), 32'd1);
        start = 1'b0; start8 = 1'b0;
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        check("first_op_ends", 32'(busy), 32'd0);

        // Identity.
        for (int z = 0; z < 64; z++) begin mem64[z] = 25'(z + 1); exp64[z] = 25'(z + 1); end
        do_op(2'b00, 1'b0, 1'b0, dcyc, rds, dns);
        check("id_done_cycle", 32'(dcyc), 32'd130);
        check("id_reads", 32'(rds), 32'd64);
        check("id_done_pulses", 32'(dns), 32'd1);
        check("id_data", 32'(diff64()), 32'd0);

        // Pi: bit (1,0) of slice 0 goes to bit (0,2).
        for (int z = 0; z < 64; z++) begin mem64[z] = 25'd0; exp64[z] = 25'd0; end
        mem64[0] = 25'h0000002; exp64[0] = 25'h0000400;
        do_op(2'b01, 1'b0, 1'b0, dcyc, rds, dns);
        check("pi_slice0", 32'(out64[0]), 32'h400);
        check("pi_data", 32'(diff64()), 32'd0);

        // Rho: (1,0) moves by 1, (2,0) by 62 (64-deep) or 6 (8-deep).
        for (int z = 0; z < 64; z++) begin mem64[z] = 25'd0; exp64[z] = 25'd0; end
        mem64[0] = 25'h0000006; exp64[1] = 25'h0000002; exp64[62] = 25'h0000004;
        mem8[0] = 25'h0000006;
        do_op(2'b10, 1'b0, 1'b0, dcyc, rds, dns);
        check("rho_slice1", 32'(out64[1]), 32'h2);
        check("rho_slice62", 32'(out64[62]), 32'h4);
        check("rho_data", 32'(diff64()), 32'd0);
        check("rho8_slice1", 32'(out8[1]), 32'h2);
        check("rho8_slice6", 32'(out8[6]), 32'h4);
        check("rho8_slice0", 32'(out8[0]), 32'h0);

        // Rho then pi, then the inv=1 pass on the result.
        for (int z = 0; z < 64; z++) begin
            mem64[z] = 25'($urandom);
            mdl_in[z] = mem64[z];
        end
        model_fwd11();
        do_op(2'b11, 1'b0, 1'b0, dcyc, rds, dns);
        check("rhopi_fwd_data", 32'(diff64()), 32'd0);
        for (int z = 0; z < 64; z++) begin
`ifdef PERM_INVERSE_EN
            exp64[z] = mdl_in[z];
`endif
            mem64[z] = out64[z];
        end
`ifndef PERM_INVERSE_EN
        for (int z = 0; z < 64; z++) mdl_in[z] = mem64[z];
        model_fwd11();
`endif
        do_op(2'b11, 1'b1, 1'b0, dcyc, rds, dns);
        check("rhopi_inv_data", 32'(diff64()), 32'd0);

        // Reset asserted mid-store.
        for (int z = 0; z < 64; z++) mem64[z] = 25'($urandom);
        @(negedge clk);
        mode = 2'b00; start = 1'b1; w0 = wr_cnt; d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        @(posedge clk);
        while ((wr_cnt - w0) < 10 && n < 300) begin @(posedge clk); n++; end
        check("mid_writes_seen", 32'(wr_cnt - w0), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wr_data", 32'(wr_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_idle", 32'(busy), 32'd0);

        // Fresh operation with start pulses while busy.
        for (int z = 0; z < 64; z++) begin mem64[z] = 25'(z * 3 + 7); exp64[z] = 25'(z * 3 + 7); end
        do_op(2'b00, 1'b0, 1'b1, dcyc, rds, dns);
        check("after_done_cycle", 32'(dcyc), 32'd130);
        check("after_reads", 32'(rds), 32'd64);
        check("after_done_pulses", 32'(dns), 32'd1);
        check("after_data", 32'(diff64()), 32'd0);
        check("after_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slice_perm_engine.md
# slice_perm_engine

Parametrised successor of the slice permutation block: reads a DEPTH-slice state (each slice a 25-bit 5x5 bit matrix, bit index 5*y+x) from an external memory, applies a selectable lane permutation (identity, pi, rho, rho-then-pi) and writes the result back slice by slice. It sits between the state memory and the round controller and replaces the fixed 64-slice, single-mode engine with a buffered engine of configurable depth and mode.

## Interface

- DEPTH, 64, number of slices (lane length); must be >= 2
- ADDR_W, 6, address width; DEPTH <= 2**ADDR_W
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  starts one operation when sampled high in IDLE
- mode  input  2  00 identity, 01 pi, 10 rho, 11 rho then pi; latched at start
- inv  input  1  inverse-direction select; latched at start (see Configuration)
- busy  output  1  high from the cycle after accepted start until done
- done  output  1  one-cycle pulse at end of operation
- rd_en  output  1  read strobe
- rd_addr  output  ADDR_W  slice address being read
- rd_data  input  25  slice data, valid exactly one cycle after rd_en
- wr_en  output  1  write strobe
- wr_addr  output  ADDR_W  slice address being written
- wr_data  output  25  permuted slice

## Operation

- Internal buffer: DEPTH x 25 flops, holds the whole input state.
- FSM: IDLE -> LOAD -> DRAIN -> STORE -> DONE -> IDLE.
- IDLE: start high -> latch mode/inv, addr counter := 0, go LOAD.
- LOAD: rd_en=1, rd_addr=counter, counter increments; after address DEPTH-1 go DRAIN.
- DRAIN: one cycle, rd_en=0, captures last rd_data; counter := 0, go STORE.
- Capture: rd_data written to buffer[addr of previous rd_en] every cycle following an rd_en.
- STORE: wr_en=1, wr_addr=counter, wr_data=f(buffer, counter); after address DEPTH-1 go DONE.
- DONE: done=1 for one cycle, go IDLE.
- Rho (forward): out[z] bit(x,y) = buf[(z - r[x,y]) mod DEPTH] bit(x,y). r in (x,y) order, y=0: 0,1,62,28,27; y=1: 36,44,6,55,20; y=2: 3,10,43,25,39; y=3: 41,45,15,21,8; y=4: 18,2,61,56,14; each taken mod DEPTH.
- Pi (forward): out bit(x,y) = in bit((x+3y) mod 5, x), per slice.
- Mode 11: rho applied first, pi applied to the rho result, same cycle.
- Identity: wr_data = buf[z].
- start while busy: ignored. mode/inv changes after latch: no effect.
- Reset mid-operation: all outputs and FSM return to reset values immediately; partial writes are not undone; buffer contents undefined but never emitted.

## Timing

- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0; FSM IDLE.
- start sampled at edge k: rd_en high cycles k+1..k+DEPTH, addresses 0..DEPTH-1 ascending.
- Last rd_data captured at end of DRAIN cycle k+DEPTH+1.
- wr_en high cycles k+DEPTH+2..k+2*DEPTH+1, addresses 0..DEPTH-1; wr_data registered, aligned with wr_en/wr_addr.
- done high cycle k+2*DEPTH+2; busy high k+1..k+2*DEPTH+2 inclusive. Default DEPTH=64: done 130 cycles after start edge.
- Earliest next start accepted: cycle k+2*DEPTH+3 (back in IDLE); start held high then launches immediately.
- Counters wrap never occurs: counter compared to DEPTH-1, not 2**ADDR_W-1.

## Configuration

- PERM_INVERSE_EN defined: inv=1 selects inverse permutations. Inverse rho: out[z] bit(x,y) = buf[(z + r[x,y]) mod DEPTH] bit(x,y). Inverse pi: out bit(x,y) = in bit(y, (2x+3y) mod 5). Mode 11 with inv=1 applies inverse pi then inverse rho (exact inverse of forward 11).
- PERM_INVERSE_EN undefined: inv port present but ignored (treated as 0); no inverse logic synthesised.

## Test plan

- Reset: hold rst_n=0 with start=1 -> all outputs 0, no rd_en; release -> first rd_en at cycle after start sample, rd_addr=0.
- Identity, DEPTH=64, slice z = z+1 -> 64 writes, wr_data[z]=z+1, done 130 cycles after start edge, single-cycle pulse.
- Pi, slice 0 = 25'h0000002 (bit (1,0)), rest 0 -> written slice 0 = bit (0,2) only, i.e. 25'h0000400.
- Rho, DEPTH=64, only bit (1,0) of slice 0 set -> appears only in slice 1; bit (2,0) of slice 0 -> slice 62; DEPTH=8 build: (2,0) -> slice 6.
- PERM_INVERSE_EN: random state, mode 11 forward then mode 11 inv=1 on the result -> original state restored; without macro inv=1 gives forward result.
- Reset asserted mid-STORE (after 10 writes) -> wr_en drops asynchronously, done never pulses; new start afterwards completes normally; start pulses while busy produce no extra reads.
